pe_dbuf: RTL and testbench

Parametrised systolic processing element with a double-buffered weight register for the weight-stationary TPU array. The next layer's weight is shifted into a shadow register while the current layer is still computing. A swap token travelling with the activation wavefront promotes the shadow weight to active without stalling the array. Activations, swap tokens and partial sums are registered and passed to neighbour PEs with valid tags.

---
 rtl/pe_dbuf.sv | 129 ++++++++++++
 tb/tb_pe_dbuf.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dbuf.sv
// Systolic PE with a double-buffered (active/shadow) weight register and a swap token.
// Optional saturating accumulation when PE_SAT_EN is defined; otherwise psum wraps.
module pe_dbuf #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 8,
    parameter int PSUM_WIDTH = 2*DATA_WIDTH + $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic                  w_in_valid,
    output logic [DATA_WIDTH-1:0] w_pass,
    output logic                  w_pass_valid,
    input  logic [DATA_WIDTH-1:0] act_in,
    input  logic                  act_in_valid,
    input  logic                  swap_in,
    output logic [DATA_WIDTH-1:0] act_pass,
    output logic                  act_pass_valid,
    output logic                  swap_pass,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    output logic [PSUM_WIDTH-1:0] psum_out,
    output logic                  psum_out_valid,
    output logic                  swap_err,
    output logic                  sat_flag
);

    localparam int PROD_WIDTH = 2*DATA_WIDTH;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } shadow_state_t;

    shadow_state_t shadow_state, shadow_next;

    logic [DATA_WIDTH-1:0] active_w;
    logic [DATA_WIDTH-1:0] shadow_w;
    logic                  shadow_full;
    logic [DATA_WIDTH-1:0] w_eff;
    logic [PROD_WIDTH-1:0] act_ext, w_ext, prod;
    logic [PSUM_WIDTH-1:0] prod_ext;
    logic [PSUM_WIDTH-1:0] psum_next;

    assign shadow_full = (shadow_state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_state <= EMPTY;
        else     shadow_state <= shadow_next;
    end

    // A swap together with a shift leaves the shadow holding the freshly shifted weight.
    always_comb begin
        shadow_next = shadow_state;
        case (shadow_state)
            EMPTY:   if (w_in_valid) shadow_next = FULL;
            FULL:    if (swap_in && !w_in_valid) shadow_next = EMPTY;
            default: shadow_next = EMPTY;
        endcase
    end

    // The token-carrying activation already multiplies with the promoted weight.
    assign w_eff    = (swap_in && shadow_full) ? shadow_w : active_w;
    assign act_ext  = {{DATA_WIDTH{act_in[DATA_WIDTH-1]}}, act_in};
    assign w_ext    = {{DATA_WIDTH{w_eff[DATA_WIDTH-1]}}, w_eff};
    assign prod     = act_ext * w_ext;
    assign prod_ext = {{(PSUM_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

`ifdef PE_SAT_EN
    localparam logic [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    localparam logic [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

    logic [PSUM_WIDTH:0] sum_wide;
    logic                overflow;

    // One guard bit: overflow when the two top bits of the widened sum disagree.
    assign sum_wide  = {psum_in[PSUM_WIDTH-1], psum_in} + {prod_ext[PSUM_WIDTH-1], prod_ext};
    assign overflow  = sum_wide[PSUM_WIDTH] ^ sum_wide[PSUM_WIDTH-1];
    assign psum_next = overflow ? (sum_wide[PSUM_WIDTH] ? PSUM_MIN : PSUM_MAX)
                                : sum_wide[PSUM_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           sat_flag <= 1'b0;
        else if (act_in_valid && overflow) sat_flag <= 1'b1;
    end
`else
    assign psum_next = psum_in + prod_ext;
    assign sat_flag  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_w       <= '0;
            shadow_w       <= '0;
            w_pass         <= '0;
            w_pass_valid   <= 1'b0;
            act_pass       <= '0;
            act_pass_valid <= 1'b0;
            swap_pass      <= 1'b0;
            psum_out       <= '0;
            psum_out_valid <= 1'b0;
            swap_err       <= 1'b0;
        end else begin
            if (w_in_valid) begin
                shadow_w     <= w_in;
                w_pass       <= shadow_w;
                w_pass_valid <= 1'b1;
            end else begin
                w_pass_valid <= 1'b0;
            end

            if (swap_in) begin
                if (shadow_full) active_w <= shadow_w;
                else             swap_err <= 1'b1;
            end

            act_pass       <= act_in;
            act_pass_valid <= act_in_valid;
            swap_pass      <= swap_in;

            if (act_in_valid) begin
                psum_out       <= psum_next;
                psum_out_valid <= 1'b1;
            end else begin
                psum_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_dbuf.sv
// Directed testbench for pe_dbuf with hand-computed expectations (default 8-bit data, 19-bit psum).
// Overflow expectations follow PE_SAT_EN when it is defined for the build.
module tb_pe_dbuf;

    localparam int DW = 8;
    localparam int PW = 19;

    logic          clk;
    logic          rst;
    logic [DW-1:0] w_in;
    logic          w_in_valid;
    logic [DW-1:0] w_pass;
    logic          w_pass_valid;
    logic [DW-1:0] act_in;
    logic          act_in_valid;
    logic          swap_in;
    logic [DW-1:0] act_pass;
    logic          act_pass_valid;
    logic          swap_pass;
    logic [PW-1:0] psum_in;
    logic [PW-1:0] psum_out;
    logic          psum_out_valid;
    logic          swap_err;
    logic          sat_flag;

    int checks = 0;
    int errors = 0;

    pe_dbuf #(.DATA_WIDTH(DW), .SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .w_in(w_in), .w_in_valid(w_in_valid),
        .w_pass(w_pass), .w_pass_valid(w_pass_valid),
        .act_in(act_in), .act_in_valid(act_in_valid), .swap_in(swap_in),
        .act_pass(act_pass), .act_pass_valid(act_pass_valid), .swap_pass(swap_pass),
        .psum_in(psum_in), .psum_out(psum_out), .psum_out_valid(psum_out_valid),
        .swap_err(swap_err), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_in = '0; w_in_valid = 1'b0;
        act_in = '0; act_in_valid = 1'b0;
        swap_in = 1'b0; psum_in = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({w_pass, w_pass_valid, act_pass, act_pass_valid, swap_pass} !== '0) begin
            errors++; $display("[TB] FAIL reset_pass: got %h required 0",
                               {w_pass, w_pass_valid, act_pass, act_pass_valid, swap_pass});
        end
        checks++;
        if ({psum_out, psum_out_valid, swap_err, sat_flag} !== '0) begin
            errors++; $display("[TB] FAIL reset_psum: got %h required 0",
                               {psum_out, psum_out_valid, swap_err, sat_flag});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_swap();
        w_in = 8'd5; w_in_valid = 1'b1;
        tick();
        checks++;
        if (w_pass_valid !== 1'b1 || w_pass !== 8'd0) begin
            errors++; $display("[TB] FAIL load_wpass: got %0d/%0b required 0/1", w_pass, w_pass_valid);
        end
        w_in_valid = 1'b0; swap_in = 1'b1; act_in = 8'd3; act_in_valid = 1'b1; psum_in = PW'(10);
        tick();
        checks++;
        if (psum_out !== PW'(25) || psum_out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL load_swap_mac: got %0d/%0b required 25/1",
                               $signed(psum_out), psum_out_valid);
        end
        checks++;
        if (swap_err !== 1'b0 || w_pass_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL load_swap_flags: got err=%0b wpv=%0b required 0/0",
                               swap_err, w_pass_valid);
        end
        checks++;
        if (act_pass !== 8'd3 || act_pass_valid !== 1'b1 || swap_pass !== 1'b1) begin
            errors++; $display("[TB] FAIL pass_through: got %0d/%0b/%0b required 3/1/1",
                               act_pass, act_pass_valid, swap_pass);
        end
        idle_inputs();
    endtask

    task automatic test_signed_extremes();
        w_in = 8'h80; w_in_valid = 1'b1;
        tick();
        checks++;
        if (w_pass !== 8'd5 || w_pass_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL signed_wpass: got %0d/%0b required 5/1", w_pass, w_pass_valid);
        end
        w_in_valid = 1'b0; swap_in = 1'b1; act_in = 8'h80; act_in_valid = 1'b1; psum_in = '0;
        tick();
        checks++;
        if (psum_out !== PW'(16384)) begin
            errors++; $display("[TB] FAIL signed_min_min: got %0d required 16384", $signed(psum_out));
        end
        swap_in = 1'b0; act_in = 8'd127; psum_in = PW'(-5);
        tick();
        checks++;
        if (psum_out !== PW'(-16261)) begin
            errors++; $display("[TB] FAIL signed_max_min: got %0d required -16261", $signed(psum_out));
        end
        idle_inputs();
    endtask

    task automatic test_overlap_load();
        w_in = 8'd2; w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0; swap_in = 1'b1;
        tick();
        checks++;
        if (psum_out_valid !== 1'b0 || psum_out !== PW'(-16261) || swap_pass !== 1'b1) begin
            errors++; $display("[TB] FAIL swap_no_act: got %0d/%0b/%0b required -16261/0/1",
                               $signed(psum_out), psum_out_valid, swap_pass);
        end
        swap_in = 1'b0; act_in = 8'd4; act_in_valid = 1'b1; psum_in = '0;
        w_in = 8'd7; w_in_valid = 1'b1;
        tick();
        checks++;
        if (psum_out !== PW'(8) || w_pass !== 8'd2 || w_pass_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL overlap_load: got %0d/%0d/%0b required 8/2/1",
                               $signed(psum_out), w_pass, w_pass_valid);
        end
        w_in_valid = 1'b0;
        tick();
        checks++;
        if (psum_out !== PW'(8)) begin
            errors++; $display("[TB] FAIL overlap_hold_w: got %0d required 8", $signed(psum_out));
        end
        swap_in = 1'b1;
        tick();
        checks++;
        if (psum_out !== PW'(28)) begin
            errors++; $display("[TB] FAIL overlap_swap: got %0d required 28", $signed(psum_out));
        end
        swap_in = 1'b0;
        tick();
        checks++;
        if (psum_out !== PW'(28) || swap_err !== 1'b0) begin
            errors++; $display("[TB] FAIL overlap_after: got %0d/%0b required 28/0",
                               $signed(psum_out), swap_err);
        end
        idle_inputs();
    endtask

    task automatic test_swap_and_shift();
        w_in = 8'd9; w_in_valid = 1'b1;
        tick();
        checks++;
        if (w_pass !== 8'd7) begin
            errors++; $display("[TB] FAIL shift_wpass7: got %0d required 7", w_pass);
        end
        w_in = 8'd11; swap_in = 1'b1; act_in = 8'd1; act_in_valid = 1'b1; psum_in = '0;
        tick();
        checks++;
        if (psum_out !== PW'(9) || w_pass !== 8'd9 || w_pass_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL swap_shift: got %0d/%0d/%0b required 9/9/1",
                               $signed(psum_out), w_pass, w_pass_valid);
        end
        w_in_valid = 1'b0;
        tick();
        checks++;
        if (psum_out !== PW'(11) || swap_err !== 1'b0) begin
            errors++; $display("[TB] FAIL second_swap: got %0d/%0b required 11/0",
                               $signed(psum_out), swap_err);
        end
        swap_in = 1'b0; act_in = 8'd3;
        tick();
        checks++;
        if (psum_out !== PW'(33)) begin
            errors++; $display("[TB] FAIL active_11: got %0d required 33", $signed(psum_out));
        end
        idle_inputs();
    endtask

    task automatic test_empty_swap();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (psum_out !== '0 || w_pass !== '0 || act_pass_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset: got %0d/%0d/%0b required 0/0/0",
                               $signed(psum_out), w_pass, act_pass_valid);
        end
        tick();
        rst = 1'b0;
        tick();
        swap_in = 1'b1; act_in = 8'd1; act_in_valid = 1'b1; psum_in = PW'(42);
        tick();
        checks++;
        if (psum_out !== PW'(42) || swap_err !== 1'b1) begin
            errors++; $display("[TB] FAIL empty_swap: got %0d/%0b required 42/1",
                               $signed(psum_out), swap_err);
        end
        swap_in = 1'b0; act_in = 8'd5; psum_in = PW'(-3);
        tick();
        tick();
        checks++;
        if (psum_out !== PW'(-3) || swap_err !== 1'b1) begin
            errors++; $display("[TB] FAIL err_sticky: got %0d/%0b required -3/1",
                               $signed(psum_out), swap_err);
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (swap_err !== 1'b0) begin
            errors++; $display("[TB] FAIL err_clear: got %0b required 0", swap_err);
        end
    endtask

    task automatic test_overflow();
        w_in = 8'd1; w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0; swap_in = 1'b1; act_in = 8'd1; act_in_valid = 1'b1;
        psum_in = PW'(262143);
        tick();
        checks++;
`ifdef PE_SAT_EN
        if (psum_out !== PW'(262143) || sat_flag !== 1'b1) begin
            errors++; $display("[TB] FAIL overflow_pos: got %0d/%0b required 262143/1",
                               $signed(psum_out), sat_flag);
        end
`else
        if (psum_out !== PW'(-262144) || sat_flag !== 1'b0) begin
            errors++; $display("[TB] FAIL overflow_pos: got %0d/%0b required -262144/0",
                               $signed(psum_out), sat_flag);
        end
`endif
        swap_in = 1'b0; act_in = 8'hFF; psum_in = PW'(-262144);
        tick();
        checks++;
`ifdef PE_SAT_EN
        if (psum_out !== PW'(-262144) || sat_flag !== 1'b1) begin
            errors++; $display("[TB] FAIL overflow_neg: got %0d/%0b required -262144/1",
                               $signed(psum_out), sat_flag);
        end
`else
        if (psum_out !== PW'(262143) || sat_flag !== 1'b0) begin
            errors++; $display("[TB] FAIL overflow_neg: got %0d/%0b required 262143/0",
                               $signed(psum_out), sat_flag);
        end
`endif
        act_in = 8'd2; psum_in = PW'(100);
        tick();
        checks++;
        if (psum_out !== PW'(102)) begin
            errors++; $display("[TB] FAIL no_overflow: got %0d required 102", $signed(psum_out));
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #3;
        test_reset();
        test_load_swap();
        test_signed_extremes();
        test_overlap_load();
        test_swap_and_shift();
        test_empty_swap();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
